// File: rtl/dfg_loop_ring_pkg.sv
// dfg_loop_ring_pkg: shared FSM states, loop-mode constants and the ring loop operator
package dfg_loop_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int MODE_ADD = 0;
  localparam int MODE_XOR = 1;
  // Operator is evaluated at a fixed wide width; callers truncate to their channel width.
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] loop_op(input int mode, input logic [MAX_W-1:0] s, input logic [MAX_W-1:0] p);
    return mode == MODE_XOR ? (s ^ p) + MAX_W'(1) : s + p + MAX_W'(1);
  endfunction
endpackage

// File: rtl/dfg_loop_ring_cell.sv
// dfg_loop_cell: one ring channel register, loaded from a seed or advanced by the loop operator
module dfg_loop_cell
  import dfg_loop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_ADD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] pred_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  // load wins over advance; otherwise hold
  always_comb q_d = load_i ? load_val_i : en_i ? WIDTH'(loop_op(MODE, MAX_W'(q_q), MAX_W'(pred_i))) : q_q;
  // channel register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/dfg_loop_ring.sv
// dfg_loop_ring: ring of registered channels iterated a fixed count, then OR-reduced (optional DFG_LOOP_RING_HOLD_EN adds hold_i)
module dfg_loop_ring
  import dfg_loop_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ITERS    = 16,
  parameter int MODE     = MODE_ADD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [WIDTH-1:0]          seed_i,
`ifdef DFG_LOOP_RING_HOLD_EN
  input  logic                      hold_i,
`endif
  output logic                      busy_o,
  output logic                      done_o,
  output logic [WIDTH-1:0]          result_o,
  output logic [CHANNELS*WIDTH-1:0] chan_o
);
  localparam int CW = $clog2(ITERS + 1);
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q, nxt_or;
  logic             busy_q, done_q, load, adv, last;
  logic [WIDTH-1:0] q_w   [CHANNELS];
  logic [WIDTH-1:0] nxt_w [CHANNELS];
  assign load = state_q == IDLE && start_i;
`ifdef DFG_LOOP_RING_HOLD_EN
  assign adv = state_q == RUN && !hold_i;
`else
  assign adv = state_q == RUN;
`endif
  assign last = cnt_q == CW'(ITERS - 1);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    dfg_loop_cell #(.WIDTH(WIDTH), .MODE(MODE)) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .en_i      (adv),
      .load_val_i(seed_i + WIDTH'(c)),
      .pred_i    (q_w[(c + CHANNELS - 1) % CHANNELS]),
      .q_o       (q_w[c])
    );
    assign nxt_w[c] = WIDTH'(loop_op(MODE, MAX_W'(q_w[c]), MAX_W'(q_w[(c + CHANNELS - 1) % CHANNELS])));
    assign chan_o[c*WIDTH +: WIDTH] = q_w[c];
  end
  // OR of the values the channels take on the final update, so the result is ready on entry to DONE
  always_comb begin
    nxt_or = '0;
    for (int c = 0; c < CHANNELS; c++) nxt_or = nxt_or | nxt_w[c];
  end
  // control FSM with iteration counter and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= RUN;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        RUN: if (adv) begin
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q  <= DONE;
            result_q <= nxt_or;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
endmodule
